neuron_layer_sequencer: RTL and testbench
=========================================

// Module: neuron_layer_sequencer
// PURPOSE
//  Time-multiplexes one parallel neuron+ReLU datapath (top_neuron_relu) across NUM_NEURONS outputs of a layer.
//  Per neuron: fetches that neuron's weight row and bias from weight memory, fires the datapath, captures its output.
//  Outputs are collected into an output buffer. Sits between layer-level control (start/done) and the shared neuron datapath.
// PARAMETERS
//  INPUT_WIDTH    10  activations per neuron (datapath fan-in)
//  DATA_WIDTH     16  signed activation/weight/bias/output width
//  NUM_NEURONS    4   neurons in the layer; >=1
//  TIMEOUT_CYCLES 64  WAIT watchdog limit (used only with NEURON_SEQ_TIMEOUT_EN)
// PORTS
//  clk            in   1                   clock
//  rst_n          in   1                   reset, asynchronous, active-high (asserted when rst_n=1)
//  start          in   1                   begin layer; sampled only in IDLE
//  a_vec          in   INPUT_WIDTH*DW      layer activations; element i = [i*DW +: DW]; latched on accepted start
//  busy           out  1                   high in every state except IDLE
//  done           out  1                   1-cycle pulse: layer complete
//  error          out  1                   sticky timeout flag; cleared on accepted start (timeout build only)
//  out_vec        out  NUM_NEURONS*DW      output buffer; neuron k = [k*DW +: DW]
//  w_rd_en        out  1                   weight-memory read strobe
//  w_addr         out  $clog2(NUM_NEURONS) row index (min width 1)
//  w_rd_data      in   INPUT_WIDTH*DW      weight row; valid the cycle after w_rd_en
//  b_rd_data      in   DW                  bias; same timing as w_rd_data
//  n_valid_in     out  1                   fire pulse to datapath
//  n_a, n_w       out  INPUT_WIDTH*DW      activations / weights to datapath
//  n_bias         out  DW                  bias to datapath
//  n_valid_out    in   1                   datapath result valid
//  n_out          in   DW                  datapath result (post-ReLU)
// BEHAVIOUR
//  Reset (async, rst_n=1):
//   - state=IDLE; idx=0.
//   - busy, done, error, w_rd_en, n_valid_in = 0.
//   - out_vec, n_a, n_w, n_bias = 0.
//   - Reset mid-layer aborts immediately; no done pulse.
//  FSM, one state per cycle unless noted:
//   - IDLE: start=1 -> latch a_vec into n_a; idx=0; error=0 -> FETCH.
//   - FETCH: w_rd_en=1, w_addr=idx -> LOAD.
//   - LOAD: latch w_rd_data->n_w, b_rd_data->n_bias -> FIRE.
//     n_a/n_w/n_bias are held stable from LOAD until the next LOAD or IDLE.
//   - FIRE: n_valid_in=1 for exactly one cycle -> WAIT.
//   - WAIT: stays until n_valid_out=1. That cycle: out_vec[idx]<=n_out;
//     if idx==NUM_NEURONS-1 -> DONE, else idx++ -> FETCH.
//   - DONE: done=1 -> IDLE.
//  Latency:
//   - datapath latency L>=1 cycles (FIRE -> n_valid_out).
//   - per neuron = 3+L cycles; layer = NUM_NEURONS*(3+L)+1 cycles, from the start-accept edge to done.
//  Boundaries:
//   - start while busy: ignored. start in the DONE cycle: ignored; start must be re-presented in IDLE.
//   - n_valid_out outside WAIT (incl. FIRE): ignored, no buffer write.
//   - NUM_NEURONS=1: FETCH..WAIT once, then DONE; no idx wrap.
//   - out_vec entries not yet rewritten keep their previous-layer values until overwritten.
// CONFIGURATION
//  NEURON_SEQ_TIMEOUT_EN defined:
//   - cycle counter, zeroed on entering WAIT.
//   - TIMEOUT_CYCLES cycles in WAIT without n_valid_out -> error=1, out_vec[idx] unchanged, -> DONE (done still pulses).
//  Undefined: no counter; WAIT waits indefinitely; error tied 0.
// TESTING
//  1 Real top_neuron_relu, N=2. Row0 w={-10,12,89,300,2,9,56,12,7,107}, bias 0; row1 = -row0;
//    a={10,2,99,-9,5,50,-105,20,83,39} -> out_vec[0]=5609, out_vec[1]=0, one done pulse.
//  2 Model datapath L=2, N=4, rows return k+1 -> done exactly 21 cycles after start-accept edge;
//    out_vec={4,3,2,1}; w_addr sequence 0,1,2,3.
//  3 start pulsed during WAIT of neuron 1 and in the DONE cycle -> no restart;
//    exactly one done; busy drops the cycle after done.
//  4 rst_n=1 asserted during WAIT of neuron 2 -> same-cycle async clear:
//    busy=0, out_vec=0, state IDLE; no done; fresh start completes normally.
//  5 Spurious n_valid_out in IDLE and FIRE -> out_vec unchanged; sequence timing identical to test 2.
//  6 NEURON_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=8, model never responds for neuron 1 ->
//    error=1, done pulses, out_vec[1] unchanged; next accepted start clears error.

Source files
------------

// File: rtl/neuron_layer_sequencer.sv
// rtl/neuron_layer_sequencer.sv - time-multiplexes one neuron+ReLU datapath across a layer.
// Optional WAIT watchdog enabled by defining NEURON_SEQ_TIMEOUT_EN.
module neuron_layer_sequencer #(
  parameter int INPUT_WIDTH    = 10,
  parameter int DATA_WIDTH     = 16,
  parameter int NUM_NEURONS    = 4,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int AW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic [INPUT_WIDTH*DATA_WIDTH-1:0] a_vec,
  output logic                              busy,
  output logic                              done,
  output logic                              error,
  output logic [NUM_NEURONS*DATA_WIDTH-1:0] out_vec,
  output logic                              w_rd_en,
  output logic [AW-1:0]                     w_addr,
  input  logic [INPUT_WIDTH*DATA_WIDTH-1:0] w_rd_data,
  input  logic [DATA_WIDTH-1:0]             b_rd_data,
  output logic                              n_valid_in,
  output logic [INPUT_WIDTH*DATA_WIDTH-1:0] n_a,
  output logic [INPUT_WIDTH*DATA_WIDTH-1:0] n_w,
  output logic [DATA_WIDTH-1:0]             n_bias,
  input  logic                              n_valid_out,
  input  logic [DATA_WIDTH-1:0]             n_out
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_FIRE, S_WAIT, S_DONE
  } state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_NEURONS - 1);

  state_t        state;
  logic [AW-1:0] idx;

  assign w_addr = idx;

`ifdef NEURON_SEQ_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  logic [CW-1:0] wait_cnt;
  logic          timeout_hit;
  assign timeout_hit = (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign error = 1'b0;
`endif

  // Reset is asserted high on rst_n, matching the rest of this codebase.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state      <= S_IDLE;
      idx        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      w_rd_en    <= 1'b0;
      n_valid_in <= 1'b0;
      out_vec    <= '0;
      n_a        <= '0;
      n_w        <= '0;
      n_bias     <= '0;
`ifdef NEURON_SEQ_TIMEOUT_EN
      error      <= 1'b0;
      wait_cnt   <= '0;
`endif
    end else begin
      done       <= 1'b0;
      w_rd_en    <= 1'b0;
      n_valid_in <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            n_a     <= a_vec;
            idx     <= '0;
            busy    <= 1'b1;
            w_rd_en <= 1'b1;
`ifdef NEURON_SEQ_TIMEOUT_EN
            error   <= 1'b0;
`endif
            state   <= S_FETCH;
          end
        end
        S_FETCH: state <= S_LOAD;
        S_LOAD: begin
          n_w        <= w_rd_data;
          n_bias     <= b_rd_data;
          n_valid_in <= 1'b1;
          state      <= S_FIRE;
        end
        S_FIRE: begin
`ifdef NEURON_SEQ_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (n_valid_out) begin
            out_vec[int'(idx)*DATA_WIDTH +: DATA_WIDTH] <= n_out;
            if (idx == LAST_IDX) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              idx     <= idx + 1'b1;
              w_rd_en <= 1'b1;
              state   <= S_FETCH;
            end
          end
`ifdef NEURON_SEQ_TIMEOUT_EN
          // A stuck datapath abandons the layer but still reports completion.
          else if (timeout_hit) begin
            error <= 1'b1;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_layer_sequencer.sv
// tb/tb_neuron_layer_sequencer.sv - randomized self-checking bench for neuron_layer_sequencer.
// Define NEURON_SEQ_TIMEOUT_EN to also exercise the watchdog.
module tb_neuron_layer_sequencer;
  localparam int IW = 10;
  localparam int DW = 16;
  localparam int N  = 4;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start = 1'b0;
  logic [IW*DW-1:0] a_vec = '0;
  logic            busy, done, error, w_rd_en, n_valid_in;
  logic [N*DW-1:0] out_vec;
  logic [1:0]      w_addr;
  logic [IW*DW-1:0] w_rd_data = '0;
  logic [DW-1:0]   b_rd_data = '0;
  logic [IW*DW-1:0] n_a, n_w;
  logic [DW-1:0]   n_bias;
  logic            n_valid_out;
  logic [DW-1:0]   n_out;

  int vectors = 0;
  int fails   = 0;

  logic [IW*DW-1:0] wmem [N];
  logic [DW-1:0]    bmem [N];
  logic [IW*DW-1:0] a_lat;
  logic [N*DW-1:0]  exp_vec = '0;
  int               addr_q [$];

  int            dp_lat = 2;
  int            dp_cnt = 0;
  logic          dp_valid = 1'b0;
  logic [DW-1:0] dp_res = '0;
  int            mute_idx = -1;
  logic          spur_idle = 1'b0;
  logic          spur_fire = 1'b0;

  neuron_layer_sequencer #(
    .INPUT_WIDTH(IW), .DATA_WIDTH(DW), .NUM_NEURONS(N), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a_vec(a_vec), .busy(busy), .done(done),
    .error(error), .out_vec(out_vec), .w_rd_en(w_rd_en), .w_addr(w_addr),
    .w_rd_data(w_rd_data), .b_rd_data(b_rd_data), .n_valid_in(n_valid_in),
    .n_a(n_a), .n_w(n_w), .n_bias(n_bias), .n_valid_out(n_valid_out), .n_out(n_out)
  );

  always #5 clk = ~clk;

  // Behavioural neuron: signed dot product plus bias, clamped at zero.
  function automatic logic [DW-1:0] ref_neuron(input logic [IW*DW-1:0] a,
                                               input logic [IW*DW-1:0] w,
                                               input logic [DW-1:0] b);
    longint s, x, y;
    s = longint'($signed(b));
    for (int i = 0; i < IW; i++) begin
      x = longint'($signed(a[i*DW +: DW]));
      y = longint'($signed(w[i*DW +: DW]));
      s += x * y;
    end
    if (s < 0) s = 0;
    return s[DW-1:0];
  endfunction

  function automatic logic [IW*DW-1:0] rand_vec(input int span);
    logic [IW*DW-1:0] v;
    for (int i = 0; i < IW; i++) v[i*DW +: DW] = DW'(int'($urandom_range(0, 2*span)) - span);
    return v;
  endfunction

  always @(posedge clk) if (w_rd_en) begin
    w_rd_data <= wmem[w_addr];
    b_rd_data <= bmem[w_addr];
  end

  always @(posedge clk) begin
    dp_valid <= 1'b0;
    if (rst_n) dp_cnt <= 0;
    else if (n_valid_in) begin
      if (int'(w_addr) != mute_idx) begin
        dp_res <= ref_neuron(n_a, n_w, n_bias);
        if (dp_lat == 1) dp_valid <= 1'b1;
        else dp_cnt <= dp_lat - 1;
      end
    end else if (dp_cnt > 0) begin
      dp_cnt <= dp_cnt - 1;
      if (dp_cnt == 1) dp_valid <= 1'b1;
    end
  end

  assign n_valid_out = dp_valid | (spur_fire & n_valid_in) | (spur_idle & ~busy);
  assign n_out       = dp_valid ? dp_res : 16'h7abc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic set_exp(input int upto, input int skip);
    for (int k = 0; k < upto; k++)
      if (k != skip) exp_vec[k*DW +: DW] = ref_neuron(a_lat, wmem[k], bmem[k]);
  endtask

  task automatic randomize_mem(input int span);
    for (int k = 0; k < N; k++) begin
      wmem[k] = rand_vec(span);
      bmem[k] = DW'(int'($urandom_range(0, 2*span*span)) - span*span);
    end
  endtask

  task automatic run_layer(input int lat, input int poke_cyc, input bit poke_done,
                           output int cyc_done, output int ndone,
                           output logic busy_after, output logic err_first);
    int cyc;
    dp_lat = lat; addr_q.delete(); ndone = 0; cyc_done = -1; busy_after = 1'b1;
    a_lat = a_vec;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; a_vec = rand_vec(100);
    cyc = 1; err_first = error;
    while (cyc < 2000) begin
      if (w_rd_en) addr_q.push_back(int'(w_addr));
      if (cyc_done >= 0 && cyc == cyc_done + 1) busy_after = busy;
      if (done) begin ndone++; if (cyc_done < 0) cyc_done = cyc; end
      if (cyc_done >= 0 && cyc >= cyc_done + 4) break;
      start = (cyc == poke_cyc) || (poke_done && done);
      @(negedge clk); cyc++;
    end
    start = 1'b0;
  endtask

  function automatic logic [63:0] addr_seq();
    logic [63:0] s = '0;
    foreach (addr_q[i]) s = (s << 8) | 64'(addr_q[i]);
    return s;
  endfunction

  initial begin
    int cd, nd, r0[IW];
    logic ba, ef;
    int lat;
    bit saw_done;

    r0 = '{-10, 12, 89, 300, 2, 9, 56, 12, 7, 107};
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 0);
    check("rst_done", 64'(done), 0);
    check("rst_error", 64'(error), 0);
    check("rst_strobes", {62'b0, w_rd_en, n_valid_in}, 0);
    check("rst_out_vec", out_vec, 0);
    check("rst_n_bias", 64'(n_bias), 0);
    check("rst_n_a_w", 64'(n_a | n_w), 0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);

    // Directed rows from the datapath example, plus two extra rows.
    for (int i = 0; i < IW; i++) begin
      wmem[0][i*DW +: DW] = DW'(r0[i]);
      wmem[1][i*DW +: DW] = DW'(-r0[i]);
      wmem[3][i*DW +: DW] = DW'(r0[i]);
    end
    wmem[2] = '0; bmem[0] = '0; bmem[1] = '0; bmem[2] = 16'd7; bmem[3] = DW'(-9);
    r0 = '{10, 2, 99, -9, 5, 50, -105, 20, 83, 39};
    for (int i = 0; i < IW; i++) a_vec[i*DW +: DW] = DW'(r0[i]);
    run_layer(3, -1, 1'b0, cd, nd, ba, ef);
    set_exp(N, -1);
    check("t1_out0", 64'(out_vec[0 +: DW]), 64'd5609);
    check("t1_out1", 64'(out_vec[DW +: DW]), 64'd0);
    check("t1_out_vec", out_vec, exp_vec);
    check("t1_done_count", 64'(nd), 1);
    check("t1_n_a_latched", 64'(n_a ^ a_lat), 0);

    for (int k = 0; k < N; k++) begin wmem[k] = '0; bmem[k] = DW'(k + 1); end
    run_layer(2, -1, 1'b0, cd, nd, ba, ef);
    check("t2_latency", 64'(cd), 64'(N*(3+2)+1));
    check("t2_out_vec", out_vec, 64'h0004_0003_0002_0001);
    check("t2_addr_count", 64'(addr_q.size()), 64'(N));
    check("t2_addr_seq", addr_seq(), 64'h0001_0203);

    randomize_mem(100);
    a_vec = rand_vec(100);
    run_layer(2, 9, 1'b1, cd, nd, ba, ef);
    set_exp(N, -1);
    check("t3_done_count", 64'(nd), 1);
    check("t3_busy_after_done", 64'(ba), 0);
    check("t3_no_restart", 64'(busy), 0);
    check("t3_latency", 64'(cd), 64'(N*(3+2)+1));
    check("t3_out_vec", out_vec, exp_vec);

    // Reset in the WAIT of neuron 2 (cycle 14 with latency 2).
    dp_lat = 2;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (13) @(negedge clk);
    check("t4_busy_pre_reset", 64'(busy), 1);
    rst_n = 1'b1;
    #1;
    check("t4_busy_async", 64'(busy), 0);
    check("t4_out_vec_async", out_vec, 0);
    check("t4_strobes_async", {61'b0, w_rd_en, n_valid_in, done}, 0);
    saw_done = 1'b0;
    repeat (3) begin @(negedge clk); saw_done |= done; end
    rst_n = 1'b0;
    repeat (3) begin @(negedge clk); saw_done |= done; end
    check("t4_no_done", 64'(saw_done), 0);
    exp_vec = '0;
    a_vec = rand_vec(100);
    run_layer(2, -1, 1'b0, cd, nd, ba, ef);
    set_exp(N, -1);
    check("t4_fresh_out_vec", out_vec, exp_vec);
    check("t4_fresh_latency", 64'(cd), 64'(N*(3+2)+1));

    spur_idle = 1'b1; spur_fire = 1'b1;
    repeat (3) @(negedge clk);
    check("t5_idle_spur_out_vec", out_vec, exp_vec);
    randomize_mem(100);
    a_vec = rand_vec(100);
    run_layer(2, -1, 1'b0, cd, nd, ba, ef);
    set_exp(N, -1);
    check("t5_latency", 64'(cd), 64'(N*(3+2)+1));
    check("t5_out_vec", out_vec, exp_vec);
    spur_idle = 1'b0; spur_fire = 1'b0;

    for (int it = 0; it < 4; it++) begin
      lat = int'($urandom_range(1, 5));
      randomize_mem(150);
      a_vec = rand_vec(150);
      run_layer(lat, -1, 1'b0, cd, nd, ba, ef);
      set_exp(N, -1);
      check($sformatf("rand%0d_latency_L%0d", it, lat), 64'(cd), 64'(N*(3+lat)+1));
      check($sformatf("rand%0d_out_vec", it), out_vec, exp_vec);
      check($sformatf("rand%0d_done_count", it), 64'(nd), 1);
    end

`ifdef NEURON_SEQ_TIMEOUT_EN
    mute_idx = 1;
    randomize_mem(100);
    a_vec = rand_vec(100);
    run_layer(2, -1, 1'b0, cd, nd, ba, ef);
    set_exp(1, -1);
    check("t6_error_set", 64'(error), 1);
    check("t6_done_count", 64'(nd), 1);
    check("t6_latency", 64'(cd), 64'((3+2) + 3 + TO + 1));
    check("t6_out_vec", out_vec, exp_vec);
    mute_idx = -1;
    a_vec = rand_vec(100);
    run_layer(2, -1, 1'b0, cd, nd, ba, ef);
    set_exp(N, -1);
    check("t6_error_cleared_on_start", 64'(ef), 0);
    check("t6_error_stays_clear", 64'(error), 0);
    check("t6_recover_out_vec", out_vec, exp_vec);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit: observed timeout expected completion");
    $fatal(1, "time limit");
  end
endmodule
